// File: rtl/cv32e40x_prefetch_trans_ctrl_if.sv
// Prefetcher <-> OBI instruction-side transaction control signal bundle.
interface cv32e40x_prefetch_trans_ctrl_if;
   logic        fetch_en_i;
   logic        branch_i;
   logic [31:0] branch_addr_i;
   logic [1:0]  buf_cnt_i;
   logic        trans_valid_o;
   logic        trans_ready_i;
   logic [31:0] trans_addr_o;
   logic        resp_valid_i;
   logic        resp_valid_o;
   logic [1:0]  outstanding_o;
   logic        busy_o;

   // Side that owns the control block (drives the *_o signals)
   modport slave (
      input  fetch_en_i, branch_i, branch_addr_i, buf_cnt_i, trans_ready_i, resp_valid_i,
      output trans_valid_o, trans_addr_o, resp_valid_o, outstanding_o, busy_o
   );

   // Surrounding prefetcher / OBI port side
   modport master (
      output fetch_en_i, branch_i, branch_addr_i, buf_cnt_i, trans_ready_i, resp_valid_i,
      input  trans_valid_o, trans_addr_o, resp_valid_o, outstanding_o, busy_o
   );
endinterface

// File: rtl/cv32e40x_prefetch_trans_ctrl.sv
// Instruction-side OBI address-phase sequencer: sequential word fetch, redirect,
// outstanding/capacity throttling and dropping of stale pre-redirect responses.
module cv32e40x_prefetch_trans_ctrl #(
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter int unsigned BUF_DEPTH       = 3
) (
   input logic                           clk,
   input logic                           rst,
   cv32e40x_prefetch_trans_ctrl_if.slave bus
);

   localparam int unsigned WADDR_W = 30;
   localparam int unsigned CNT_W   = 2;
   localparam int unsigned SUM_W   = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      HOLD  = 2'd2
   } state_e;

   state_e               state_q, state_d;
   logic [WADDR_W-1:0]   addr_q, addr_d;
   logic [WADDR_W-1:0]   target_q, target_d;
   logic                 held_q, held_d;
   logic [CNT_W-1:0]     outstanding_q, outstanding_d;
   logic [CNT_W-1:0]     discard_q, discard_d;
   logic [CNT_W-1:0]     discard_dec;
   logic [SUM_W-1:0]     buf_sum;
   logic [WADDR_W-1:0]   branch_waddr;
   logic                 can_issue;
   logic                 trans_valid;
   logic                 accept;
   logic                 unused_addr_lsb;

   assign branch_waddr    = bus.branch_addr_i[31:2];
   assign unused_addr_lsb = ^bus.branch_addr_i[1:0];

   // Issue permission, valid generation (a raised valid stays up until accepted)
   always_comb begin
      buf_sum     = SUM_W'(bus.buf_cnt_i) + SUM_W'(outstanding_q) - SUM_W'(discard_q);
      can_issue   = bus.fetch_en_i
                    && (outstanding_q < CNT_W'(MAX_OUTSTANDING))
                    && (buf_sum < SUM_W'(BUF_DEPTH));
      trans_valid = held_q || (state_q == HOLD) || ((state_q == ISSUE) && can_issue);
      accept      = trans_valid && bus.trans_ready_i;
   end

   // Outstanding count after this cycle's accept/response, and discard drain
   always_comb begin
      outstanding_d = outstanding_q;
      if (accept && !bus.resp_valid_i) begin
         outstanding_d = outstanding_q + CNT_W'(1);
      end else if (!accept && bus.resp_valid_i) begin
         outstanding_d = outstanding_q - CNT_W'(1);
      end
      discard_dec = discard_q;
      if (bus.resp_valid_i && (discard_q != '0)) begin
         discard_dec = discard_q - CNT_W'(1);
      end
   end

   // Next-state, address and redirect bookkeeping
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      target_d  = target_q;
      held_d    = trans_valid && !bus.trans_ready_i;
      discard_d = discard_dec;

      unique case (state_q)
         IDLE: begin
            if (bus.branch_i) begin
               addr_d    = branch_waddr;
               discard_d = outstanding_d;
               state_d   = ISSUE;
            end else if (bus.fetch_en_i) begin
               state_d   = ISSUE;
            end
         end

         ISSUE: begin
            if (bus.branch_i && trans_valid && !bus.trans_ready_i) begin
               // Valid already on the bus: keep it stable and park the target
               target_d  = branch_waddr;
               discard_d = outstanding_d;
               state_d   = HOLD;
            end else if (bus.branch_i) begin
               // Any same-cycle accept is counted in outstanding_d and thus dropped
               addr_d    = branch_waddr;
               discard_d = outstanding_d;
            end else begin
               if (accept) begin
                  addr_d = addr_q + WADDR_W'(1);
               end
               if (!bus.fetch_en_i && !trans_valid) begin
                  state_d = IDLE;
               end
            end
         end

         HOLD: begin
            if (bus.branch_i) begin
               target_d = branch_waddr;
            end
            if (accept) begin
               // The held transaction is stale: owe one more discard
               addr_d    = bus.branch_i ? branch_waddr : target_q;
               discard_d = discard_dec + CNT_W'(1);
               state_d   = ISSUE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         addr_q        <= '0;
         target_q      <= '0;
         held_q        <= 1'b0;
         outstanding_q <= '0;
         discard_q     <= '0;
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         target_q      <= target_d;
         held_q        <= held_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
      end
   end

   // Output mapping
   assign bus.trans_valid_o = trans_valid;
   assign bus.trans_addr_o  = {addr_q, 2'b00};
   assign bus.resp_valid_o  = bus.resp_valid_i && (discard_q == '0);
   assign bus.outstanding_o = outstanding_q;
   assign bus.busy_o        = (outstanding_q != '0) || (state_q != IDLE);

`ifndef SYNTHESIS
   // A response can only answer an accepted transaction
   resp_without_txn : assert property (@(posedge clk) disable iff (rst)
      bus.resp_valid_i |-> (outstanding_q != '0))
      else $error("response received with no outstanding transaction");
`endif

endmodule

// File: tb/tb_cv32e40x_prefetch_trans_ctrl.sv
// Scoreboard bench: directed stimulus pushes expected accepted addresses and
// expected forward/drop decisions; a negedge monitor pops and compares.
module tb_cv32e40x_prefetch_trans_ctrl;

   logic clk;
   logic rst;

   cv32e40x_prefetch_trans_ctrl_if bus ();

   cv32e40x_prefetch_trans_ctrl #(
      .MAX_OUTSTANDING (2),
      .BUF_DEPTH       (3)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks;
   int n_fail;

   logic [31:0] exp_addr[$];
   logic        exp_resp[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs just after the edge, return at the next negedge
   task automatic cyc(input logic fe, input logic br, input logic [31:0] ba,
                      input logic [1:0] bc, input logic rdy, input logic rsp);
      @(posedge clk);
      #1;
      bus.fetch_en_i    = fe;
      bus.branch_i      = br;
      bus.branch_addr_i = ba;
      bus.buf_cnt_i     = bc;
      bus.trans_ready_i = rdy;
      bus.resp_valid_i  = rsp;
      @(negedge clk);
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 1'b0);
   endtask

   // Monitor: compare every accepted address and every response decision
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.trans_valid_o && bus.trans_ready_i) begin
            if (exp_addr.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_accept: got addr 0x%08h, expected no accept at %0t",
                        bus.trans_addr_o, $time);
            end else begin
               check("accept_addr", bus.trans_addr_o, exp_addr.pop_front());
            end
         end
         if (bus.resp_valid_i) begin
            if (exp_resp.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_resp: got resp_valid_o=%0b, expected no response at %0t",
                        bus.resp_valid_o, $time);
            end else begin
               check("resp_valid_o", 32'(bus.resp_valid_o), 32'(exp_resp.pop_front()));
            end
         end
         check("outstanding_le_2", 32'(bus.outstanding_o <= 2'd2), 32'd1);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      bus.fetch_en_i    = 1'b0;
      bus.branch_i      = 1'b0;
      bus.branch_addr_i = 32'h0;
      bus.buf_cnt_i     = 2'd0;
      bus.trans_ready_i = 1'b0;
      bus.resp_valid_i  = 1'b0;

      // Reset values
      idle();
      check("rst_trans_valid", 32'(bus.trans_valid_o), 32'd0);
      check("rst_trans_addr",  bus.trans_addr_o,       32'h0);
      check("rst_outstanding", 32'(bus.outstanding_o), 32'd0);
      check("rst_resp_valid",  32'(bus.resp_valid_o),  32'd0);
      check("rst_busy",        32'(bus.busy_o),        32'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Sequential fetch from 0x100 with 1-cycle responses
      cyc(1'b1, 1'b1, 32'h100, 2'd0, 1'b1, 1'b0);
      check("s1_idle_no_valid", 32'(bus.trans_valid_o), 32'd0);
      for (int i = 0; i < 6; i++) begin
         exp_addr.push_back(32'h100 + 32'(4 * i));
         if (i > 0) exp_resp.push_back(1'b1);
         cyc(1'b1, 1'b0, 32'h0, 2'd0, 1'b1, (i > 0));
      end
      exp_resp.push_back(1'b1);
      cyc(1'b0, 1'b0, 32'h0, 2'd0, 1'b1, 1'b1);
      idle();
      check("s1_outstanding_end", 32'(bus.outstanding_o), 32'd0);
      check("s1_busy_end",        32'(bus.busy_o),        32'd0);

      // Buffer-capacity throttling
      cyc(1'b1, 1'b1, 32'h200, 2'd2, 1'b1, 1'b0);
      exp_addr.push_back(32'h200);
      cyc(1'b1, 1'b0, 32'h0, 2'd2, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 1'b0, 32'h0, 2'd2, 1'b1, 1'b0);
         check("s2_throttled_valid", 32'(bus.trans_valid_o), 32'd0);
      end
      check("s2_outstanding", 32'(bus.outstanding_o), 32'd1);
      exp_addr.push_back(32'h204);
      cyc(1'b1, 1'b0, 32'h0, 2'd1, 1'b1, 1'b0);
      check("s2_released_valid", 32'(bus.trans_valid_o), 32'd1);
      exp_resp.push_back(1'b1);
      cyc(1'b0, 1'b0, 32'h0, 2'd0, 1'b1, 1'b1);
      exp_resp.push_back(1'b1);
      cyc(1'b0, 1'b0, 32'h0, 2'd0, 1'b1, 1'b1);
      idle();
      check("s2_busy_end", 32'(bus.busy_o), 32'd0);

      // Redirect with two outstanding: both stale responses dropped
      cyc(1'b1, 1'b1, 32'h1000, 2'd0, 1'b1, 1'b0);
      exp_addr.push_back(32'h1000);
      cyc(1'b1, 1'b0, 32'h0, 2'd0, 1'b1, 1'b0);
      exp_addr.push_back(32'h1004);
      cyc(1'b1, 1'b0, 32'h0, 2'd0, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, 32'h2002, 2'd0, 1'b1, 1'b0);
      check("s3_outstanding_full", 32'(bus.outstanding_o), 32'd2);
      check("s3_valid_at_max",     32'(bus.trans_valid_o), 32'd0);
      exp_resp.push_back(1'b0);
      cyc(1'b1, 1'b0, 32'h0, 2'd0, 1'b1, 1'b1);
      check("s3_redirect_addr", bus.trans_addr_o, 32'h2000);
      check("s3_busy",          32'(bus.busy_o),  32'd1);
      exp_resp.push_back(1'b0);
      exp_addr.push_back(32'h2000);
      cyc(1'b1, 1'b0, 32'h0, 2'd0, 1'b1, 1'b1);
      exp_resp.push_back(1'b1);
      cyc(1'b0, 1'b0, 32'h0, 2'd0, 1'b1, 1'b1);
      idle();

      // Branch while valid is stalled: address held, then target issued
      cyc(1'b1, 1'b1, 32'h3000, 2'd0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 32'h40, 2'd0, 1'b0, 1'b0);
      check("s4_valid_stalled", 32'(bus.trans_valid_o), 32'd1);
      cyc(1'b1, 1'b0, 32'h0, 2'd0, 1'b0, 1'b0);
      check("s4_hold_addr_1", bus.trans_addr_o, 32'h3000);
      cyc(1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 1'b0);
      check("s4_hold_addr_2",  bus.trans_addr_o,       32'h3000);
      check("s4_hold_valid_fe0", 32'(bus.trans_valid_o), 32'd1);
      cyc(1'b1, 1'b0, 32'h0, 2'd0, 1'b0, 1'b0);
      check("s4_hold_addr_3", bus.trans_addr_o, 32'h3000);
      exp_addr.push_back(32'h3000);
      cyc(1'b1, 1'b0, 32'h0, 2'd0, 1'b1, 1'b0);
      exp_resp.push_back(1'b0);
      exp_addr.push_back(32'h40);
      cyc(1'b1, 1'b0, 32'h0, 2'd0, 1'b1, 1'b1);
      exp_resp.push_back(1'b1);
      cyc(1'b0, 1'b0, 32'h0, 2'd0, 1'b1, 1'b1);
      idle();

      // Branch with same-cycle accept and response: accepted txn is stale
      cyc(1'b1, 1'b1, 32'h500, 2'd0, 1'b1, 1'b0);
      exp_addr.push_back(32'h500);
      cyc(1'b1, 1'b0, 32'h0, 2'd0, 1'b1, 1'b0);
      exp_addr.push_back(32'h504);
      exp_resp.push_back(1'b1);
      cyc(1'b1, 1'b1, 32'h600, 2'd0, 1'b1, 1'b1);
      exp_resp.push_back(1'b0);
      exp_addr.push_back(32'h600);
      cyc(1'b1, 1'b0, 32'h0, 2'd0, 1'b1, 1'b1);
      exp_resp.push_back(1'b1);
      cyc(1'b0, 1'b0, 32'h0, 2'd0, 1'b1, 1'b1);
      idle();

      // Address wrap at the top of memory, then reset mid-fetch
      cyc(1'b1, 1'b1, 32'hFFFF_FFF8, 2'd0, 1'b1, 1'b0);
      exp_addr.push_back(32'hFFFF_FFF8);
      cyc(1'b1, 1'b0, 32'h0, 2'd0, 1'b1, 1'b0);
      exp_addr.push_back(32'hFFFF_FFFC);
      exp_resp.push_back(1'b1);
      cyc(1'b1, 1'b0, 32'h0, 2'd0, 1'b1, 1'b1);
      exp_addr.push_back(32'h0000_0000);
      exp_resp.push_back(1'b1);
      cyc(1'b1, 1'b0, 32'h0, 2'd0, 1'b1, 1'b1);
      exp_addr.push_back(32'h0000_0004);
      exp_resp.push_back(1'b1);
      cyc(1'b1, 1'b0, 32'h0, 2'd0, 1'b1, 1'b1);
      @(posedge clk);
      #1;
      rst               = 1'b1;
      bus.resp_valid_i  = 1'b0;
      @(negedge clk);
      check("s6_rst_trans_valid", 32'(bus.trans_valid_o), 32'd0);
      check("s6_rst_trans_addr",  bus.trans_addr_o,       32'h0);
      check("s6_rst_outstanding", 32'(bus.outstanding_o), 32'd0);
      check("s6_rst_busy",        32'(bus.busy_o),        32'd0);
      @(posedge clk);
      #1;
      rst            = 1'b0;
      bus.fetch_en_i = 1'b0;
      idle();

      check("addr_queue_drained", 32'(exp_addr.size()), 32'd0);
      check("resp_queue_drained", 32'(exp_resp.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
